// File: rtl/sipo_pkg.sv
// Shared constants and the holding-register state type for the SIPO deserializer.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEF = 8;
  localparam int SIPO_TAP_DEF   = 4;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter: collects serial bits, flags word completion
// with a single-cycle done pulse and presents the assembled word alongside it.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter int TAP_WIDTH = 4,
  parameter int MSB_FIRST = 1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en_i,
  input  logic                 serial_i,
  input  logic                 clear_i,
  output logic [WIDTH-1:0]     word_o,
  output logic                 done_o,
  output logic [CW-1:0]        count_o,
  output logic [TAP_WIDTH-1:0] tap_o
);

  // History holds the newest bit in bit 0. Only WIDTH-1 past bits are needed to
  // assemble a word (the completing bit comes straight from serial_i), but the
  // tap may ask for up to WIDTH bits of history.
  localparam int SR_W = (TAP_WIDTH > WIDTH - 1) ? TAP_WIDTH : WIDTH - 1;

  logic [SR_W-1:0]  hist_q, hist_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] assembled;
  logic             accept;
  logic             last_bit;

  assign accept   = shift_en_i && !clear_i;
  assign last_bit = (count_q == CW'(WIDTH - 1));
  assign done_o   = accept && last_bit;
  assign count_o  = count_q;
  assign tap_o    = hist_q[TAP_WIDTH-1:0];

  // Next history is the old history moved up by one with serial_i entering at bit 0.
  // The assembled word is the same shift, including the completing bit, in
  // arrival order with the first bit at the top.
  for (genvar gi = 0; gi < SR_W; gi++) begin : g_hist
    if (gi == 0) begin : g_first
      assign hist_d[gi] = serial_i;
    end else begin : g_rest
      assign hist_d[gi] = hist_q[gi-1];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_word
    if (gi == 0) begin : g_first
      assign assembled[gi] = serial_i;
    end else begin : g_rest
      assign assembled[gi] = hist_q[gi-1];
    end
    // LSB-first framing puts the first received bit at word bit 0.
    if (MSB_FIRST != 0) begin : g_msb
      assign word_o[gi] = assembled[gi];
    end else begin : g_lsb
      assign word_o[gi] = assembled[WIDTH-1-gi];
    end
  end

  // Counter wraps to zero on the completing bit so the next frame starts cleanly.
  always_comb begin
    count_d = count_q;
    if (accept) begin
      count_d = last_bit ? '0 : count_q + CW'(1);
    end
  end

  // Shift state: clear wins over a coincident strobe; otherwise shift on accepted bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      hist_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a one-word holding register,
// ready/valid hand-off and a sticky overrun flag for dropped words.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int TAP_WIDTH = SIPO_TAP_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift_en,
  input  logic                         serial_in,
  input  logic                         clear,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             word_out,
  output logic                         word_valid,
  output logic [TAP_WIDTH-1:0]         tap_out,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] core_word;
  logic             core_done;
  hold_state_e      state_q;
  logic [WIDTH-1:0] word_q;
  logic             overrun_q;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .TAP_WIDTH (TAP_WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift_en),
    .serial_i   (serial_in),
    .clear_i    (clear),
    .word_o     (core_word),
    .done_o     (core_done),
    .count_o    (bit_count),
    .tap_o      (tap_out)
  );

  assign word_out   = word_q;
  assign word_valid = (state_q == HOLD_FULL);
  assign overrun    = overrun_q;

  // Holding FSM: load on completion when empty or when the old word leaves the
  // same cycle; drop and flag a completed word that has nowhere to go.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HOLD_EMPTY;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (clear) begin
        overrun_q <= 1'b0;
      end else if (core_done && state_q == HOLD_FULL && !out_ready) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        HOLD_EMPTY: begin
          if (core_done) begin
            word_q  <= core_word;
            state_q <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          if (core_done && out_ready) begin
            word_q <= core_word;
          end else if (!core_done && out_ready) begin
            state_q <= HOLD_EMPTY;
          end
        end
        default: state_q <= HOLD_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first
// instance driven by the same stimulus, with hand-computed expectations.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shift_en = 1'b0;
  logic       serial_in = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] m_word, l_word;
  logic       m_valid, l_valid;
  logic [3:0] m_tap, l_tap;
  logic [3:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .TAP_WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .out_ready(out_ready), .word_out(m_word), .word_valid(m_valid),
    .tap_out(m_tap), .bit_count(m_cnt), .overrun(m_ovr)
  );

  sipo_deserializer #(.WIDTH(8), .TAP_WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .out_ready(out_ready), .word_out(l_word), .word_valid(l_valid),
    .tap_out(l_tap), .bit_count(l_cnt), .overrun(l_ovr)
  );

  // One strobed bit; out_ready is held at rdy for that same cycle only.
  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    shift_en  = 1'b1;
    serial_in = b;
    out_ready = rdy;
    @(negedge clk);
    shift_en  = 1'b0;
    serial_in = 1'b0;
    out_ready = 1'b0;
  endtask

  // Eight bits, v[7] sent first; last_rdy raises out_ready on the completing bit.
  task automatic send_seq(input logic [7:0] v, input logic last_rdy);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], (i == 0) ? last_rdy : 1'b0);
    end
  endtask

  task automatic accept_word();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++; if (m_word !== 8'h00) begin bad++; $display("FAIL reset_word got=%h exp=00", m_word); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    total++; if (m_cnt !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", m_cnt); end
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", m_ovr); end
    total++; if (m_tap !== 4'h0) begin bad++; $display("FAIL reset_tap got=%h exp=0", m_tap); end
    total++; if (l_valid !== 1'b0 || l_word !== 8'h00) begin bad++; $display("FAIL reset_lsb got=%b/%h exp=0/00", l_valid, l_word); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || m_cnt !== 4'd0) begin bad++; $display("FAIL reset_release got=%b/%0d exp=0/0", m_valid, m_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_msb_first();
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    total++; if (m_cnt !== 4'd7) begin bad++; $display("FAIL msb_count7 got=%0d exp=7", m_cnt); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid got=%b exp=0", m_valid); end
    total++; if (m_tap !== 4'h2) begin bad++; $display("FAIL msb_tap7 got=%h exp=2", m_tap); end
    send_bit(v[0], 1'b0);
    total++; if (m_word !== 8'hA5) begin bad++; $display("FAIL msb_word got=%h exp=a5", m_word); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b exp=1", m_valid); end
    total++; if (m_cnt !== 4'd0) begin bad++; $display("FAIL msb_count_wrap got=%0d exp=0", m_cnt); end
    total++; if (m_tap !== 4'h5) begin bad++; $display("FAIL msb_tap got=%h exp=5", m_tap); end
    total++; if (l_word !== 8'hA5) begin bad++; $display("FAIL lsb_word_a5 got=%h exp=a5", l_word); end
    // Word must hold while unaccepted, and leave on out_ready.
    repeat (3) @(negedge clk);
    total++; if (m_word !== 8'hA5 || m_valid !== 1'b1) begin bad++; $display("FAIL msb_hold got=%h/%b exp=a5/1", m_word, m_valid); end
    accept_word();
    total++; if (m_valid !== 1'b0 || l_valid !== 1'b0) begin bad++; $display("FAIL msb_accept got=%b/%b exp=0/0", m_valid, l_valid); end
    total++; if (m_word !== 8'hA5) begin bad++; $display("FAIL msb_word_after_accept got=%h exp=a5", m_word); end
    // out_ready while empty does nothing.
    accept_word();
    total++; if (m_valid !== 1'b0 || m_word !== 8'hA5) begin bad++; $display("FAIL empty_ready got=%b/%h exp=0/a5", m_valid, m_word); end
    $display("test_msb_first done");
  endtask

  task automatic test_lsb_first();
    send_seq(8'b1100_0000, 1'b0);
    total++; if (l_word !== 8'h03) begin bad++; $display("FAIL lsb_word got=%h exp=03", l_word); end
    total++; if (m_word !== 8'hC0) begin bad++; $display("FAIL msb_word_c0 got=%h exp=c0", m_word); end
    total++; if (l_tap !== 4'h0) begin bad++; $display("FAIL lsb_tap got=%h exp=0", l_tap); end
    accept_word();
    $display("test_lsb_first done");
  endtask

  task automatic test_overrun();
    send_seq(8'hA5, 1'b0);
    send_seq(8'h3C, 1'b0);
    total++; if (m_word !== 8'hA5) begin bad++; $display("FAIL ovr_word_kept got=%h exp=a5", m_word); end
    total++; if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", m_ovr); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", m_valid); end
    @(negedge clk);
    total++; if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", m_ovr); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", m_ovr); end
    total++; if (m_valid !== 1'b1 || m_word !== 8'hA5) begin bad++; $display("FAIL clear_keeps_hold got=%b/%h exp=1/a5", m_valid, m_word); end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    // Still holding 0xA5; completion of 0x3C coincides with acceptance.
    send_seq(8'h3C, 1'b1);
    total++; if (m_word !== 8'h3C) begin bad++; $display("FAIL b2b_word got=%h exp=3c", m_word); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", m_valid); end
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", m_ovr); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midframe();
    // 0x3C still held; five bits of a new frame then asynchronous reset.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    total++; if (m_cnt !== 4'd5) begin bad++; $display("FAIL mid_count5 got=%0d exp=5", m_cnt); end
    #2 reset = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0 || m_word !== 8'h00) begin bad++; $display("FAIL async_reset_hold got=%b/%h exp=0/00", m_valid, m_word); end
    total++; if (m_cnt !== 4'd0 || m_tap !== 4'h0 || m_ovr !== 1'b0) begin bad++; $display("FAIL async_reset_core got=%0d/%h/%b exp=0/0/0", m_cnt, m_tap, m_ovr); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (m_cnt !== 4'(i)) begin bad++; $display("FAIL ff_count got=%0d exp=%0d", m_cnt, i); end
      send_bit(1'b1, 1'b0);
    end
    total++; if (m_cnt !== 4'd0) begin bad++; $display("FAIL ff_count_wrap got=%0d exp=0", m_cnt); end
    total++; if (m_word !== 8'hFF || m_valid !== 1'b1) begin bad++; $display("FAIL ff_word got=%h/%b exp=ff/1", m_word, m_valid); end
    accept_word();
    $display("test_reset_midframe done");
  endtask

  task automatic test_clear_shift();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    shift_en  = 1'b1;
    serial_in = 1'b1;
    clear     = 1'b1;
    @(negedge clk);
    shift_en  = 1'b0;
    serial_in = 1'b0;
    clear     = 1'b0;
    total++; if (m_cnt !== 4'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", m_cnt); end
    total++; if (m_tap !== 4'h0) begin bad++; $display("FAIL clear_tap got=%h exp=0", m_tap); end
    // No strobe: serial_in activity must not shift anything.
    @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    serial_in = 1'b0;
    total++; if (m_cnt !== 4'd0 || m_tap !== 4'h0) begin bad++; $display("FAIL idle_hold got=%0d/%h exp=0/0", m_cnt, m_tap); end
    send_seq(8'h81, 1'b0);
    total++; if (m_word !== 8'h81) begin bad++; $display("FAIL post_clear_word got=%h exp=81", m_word); end
    total++; if (l_word !== 8'h81) begin bad++; $display("FAIL post_clear_lsb got=%h exp=81", l_word); end
    $display("test_clear_shift done");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_clear_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
